// File: rtl/cnn_mem_pkg.sv
// Shared types and register map for the CNN weight/image loader.
package cnn_mem_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_CTRL        = 3'd0;
  localparam logic [ADDR_W-1:0] REG_STATUS      = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PARAM_DATA  = 3'd2;
  localparam logic [ADDR_W-1:0] REG_IMG_DATA    = 3'd3;
  localparam logic [ADDR_W-1:0] REG_PARAM_COUNT = 3'd4;
  localparam logic [ADDR_W-1:0] REG_IMG_COUNT   = 3'd5;
  localparam logic [ADDR_W-1:0] REG_RESULT      = 3'd6;

  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_START = 1;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_PARAM_FULL = 2;
  localparam int STAT_IMG_FULL   = 3;
  localparam int STAT_OVF        = 4;
  localparam int STAT_ERR        = 5;
endpackage

// File: rtl/cnn_mem_loader_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge and the loader.
interface cnn_mem_loader_if
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W = 8
) ();
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/cnn_buf.sv
// Simple dual-port RAM: one write port, one read port with 1-cycle latency.
// No reset on the array so it maps onto block RAM.
module cnn_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cnn_mem_loader.sv
// HPS-facing loader: fills weight/image buffers via auto-increment pointers,
// runs the start/done handshake with the CNN core and latches its result.
module cnn_mem_loader
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARAM_DEPTH = 64,
  parameter int IMG_DEPTH   = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  cnn_mem_loader_if.slave                bus,
  output logic                           core_start,
  input  logic                           core_done,
  input  logic [DATA_W-1:0]              core_result,
  input  logic [$clog2(PARAM_DEPTH)-1:0] param_raddr,
  output logic [DATA_W-1:0]              param_rdata,
  input  logic [$clog2(IMG_DEPTH)-1:0]   img_raddr,
  output logic [DATA_W-1:0]              img_rdata
);
  localparam int PAW   = $clog2(PARAM_DEPTH);
  localparam int IAW   = $clog2(IMG_DEPTH);
  localparam int PCW   = $clog2(PARAM_DEPTH + 1);
  localparam int ICW   = $clog2(IMG_DEPTH + 1);
  localparam int MAX_D = (PARAM_DEPTH > IMG_DEPTH) ? PARAM_DEPTH : IMG_DEPTH;

  if (DATA_W < $clog2(MAX_D + 1) || (DATA_W % 8) != 0) begin : g_bad_width
    $error("cnn_mem_loader: DATA_W must be a multiple of 8 wide enough for the counts");
  end

  state_t            state, state_n;
  logic [PCW-1:0]    pptr, pptr_n;
  logic [ICW-1:0]    iptr, iptr_n;
  logic              ovf, ovf_n;
  logic              err, err_n;
  logic [DATA_W-1:0] result, result_n;
  logic [DATA_W-1:0] rdata_q, rd_mux;
  logic              core_start_n;

  logic wr, rd, clear, start;
  logic p_wr, i_wr, p_full, i_full, p_we, i_we;

  assign wr     = bus.chipselect & bus.write;
  assign rd     = bus.chipselect & bus.read;
  assign clear  = wr && (bus.address == REG_CTRL) && bus.writedata[CTRL_CLEAR];
  assign start  = wr && (bus.address == REG_CTRL) && bus.writedata[CTRL_START]
                  && !bus.writedata[CTRL_CLEAR];
  assign p_wr   = wr && (bus.address == REG_PARAM_DATA);
  assign i_wr   = wr && (bus.address == REG_IMG_DATA);
  assign p_full = (pptr == PCW'(PARAM_DEPTH));
  assign i_full = (iptr == ICW'(IMG_DEPTH));
  assign p_we   = p_wr && (state != RUN) && !p_full;
  assign i_we   = i_wr && (state != RUN) && !i_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pptr       <= '0;
      iptr       <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      rdata_q    <= '0;
      core_start <= 1'b0;
    end else begin
      state      <= state_n;
      pptr       <= pptr_n;
      iptr       <= iptr_n;
      ovf        <= ovf_n;
      err        <= err_n;
      result     <= result_n;
      core_start <= core_start_n;
      if (rd) rdata_q <= rd_mux;
    end
  end

  always_comb begin
    state_n      = state;
    pptr_n       = pptr;
    iptr_n       = iptr;
    ovf_n        = ovf;
    err_n        = err;
    result_n     = result;
    core_start_n = 1'b0;

    // CLEAR outranks everything else in its cycle, including a core_done.
    if (clear) begin
      state_n = IDLE;
      pptr_n  = '0;
      iptr_n  = '0;
      ovf_n   = 1'b0;
      err_n   = 1'b0;
    end else begin
      if (p_we) pptr_n = pptr + PCW'(1);
      if (i_we) iptr_n = iptr + ICW'(1);
      if (state != RUN && ((p_wr && p_full) || (i_wr && i_full))) ovf_n = 1'b1;
      if (state == RUN && (p_wr || i_wr)) err_n = 1'b1;

      case (state)
        RUN: begin
          if (core_done) begin
            result_n = core_result;
            state_n  = DONE;
          end
        end
        default: begin
          if (state == DONE && rd && bus.address == REG_RESULT) state_n = IDLE;
          if (start) begin
            if (pptr != '0 && iptr != '0) begin
              state_n      = RUN;
              core_start_n = 1'b1;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      REG_STATUS: begin
        rd_mux[STAT_BUSY]       = (state == RUN);
        rd_mux[STAT_DONE]       = (state == DONE);
        rd_mux[STAT_PARAM_FULL] = p_full;
        rd_mux[STAT_IMG_FULL]   = i_full;
        rd_mux[STAT_OVF]        = ovf;
        rd_mux[STAT_ERR]        = err;
      end
      REG_PARAM_COUNT: rd_mux = DATA_W'(pptr);
      REG_IMG_COUNT:   rd_mux = DATA_W'(iptr);
      REG_RESULT:      rd_mux = result;
      default:         rd_mux = '0;
    endcase
  end

  assign bus.readdata = rdata_q;

  cnn_buf #(.DATA_W(DATA_W), .DEPTH(PARAM_DEPTH)) u_param_buf (
    .clk   (clk),
    .we    (p_we),
    .waddr (pptr[PAW-1:0]),
    .wdata (bus.writedata),
    .raddr (param_raddr),
    .rdata (param_rdata)
  );

  cnn_buf #(.DATA_W(DATA_W), .DEPTH(IMG_DEPTH)) u_img_buf (
    .clk   (clk),
    .we    (i_we),
    .waddr (iptr[IAW-1:0]),
    .wdata (bus.writedata),
    .raddr (img_raddr),
    .rdata (img_rdata)
  );
endmodule

// File: tb/tb_cnn_mem_loader.sv
// Scoreboard bench for cnn_mem_loader: expectations queued with stimulus, compared as outputs arrive.
module tb_cnn_mem_loader;
  import cnn_mem_pkg::*;

  logic       clk;
  logic       reset;
  logic       core_start;
  logic       core_done;
  logic [7:0] core_result;
  logic [5:0] param_raddr;
  logic [7:0] param_rdata;
  logic [6:0] img_raddr;
  logic [7:0] img_rdata;

  cnn_mem_loader_if #(.DATA_W(8)) bus ();

  cnn_mem_loader #(.DATA_W(8), .PARAM_DEPTH(64), .IMG_DEPTH(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .param_raddr (param_raddr),
    .param_rdata (param_rdata),
    .img_raddr   (img_raddr),
    .img_rdata   (img_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] obs_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         start_cnt = 0;
  int         exp_pulses = 0;

  always @(posedge clk) if (core_start === 1'b1) start_cnt++;

  task automatic want(input string n, input logic [7:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic obs(input logic [7:0] v);
    obs_q.push_back(v);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read = 1'b0;
    obs(bus.readdata);
  endtask

  task automatic pulse_done(input logic [7:0] r);
    @(negedge clk);
    core_done = 1'b1; core_result = r;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] e, o; string nm;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    want("rst_status", 8'h00);      bus_read(REG_STATUS);
    want("rst_pcount", 8'h00);      bus_read(REG_PARAM_COUNT);
    want("rst_icount", 8'h00);      bus_read(REG_IMG_COUNT);
    want("rst_core_start", 8'h00);  obs({7'd0, core_start});
    want("rst_pulses", 8'(exp_pulses)); obs(8'(start_cnt));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_load;
    logic [7:0] e, o; string nm;
    bus_write(REG_PARAM_DATA, 8'h11);
    bus_write(REG_PARAM_DATA, 8'h22);
    bus_write(REG_PARAM_DATA, 8'h33);
    bus_write(REG_IMG_DATA, 8'hA1);
    bus_write(REG_IMG_DATA, 8'hA2);
    want("load_pcount", 8'd3); bus_read(REG_PARAM_COUNT);
    want("load_icount", 8'd2); bus_read(REG_IMG_COUNT);
    @(negedge clk); param_raddr = 6'd2; img_raddr = 7'd1;
    @(negedge clk);
    want("param_rd2", 8'h33); obs(param_rdata);
    want("img_rd1", 8'hA2);   obs(img_rdata);
    param_raddr = 6'd0;
    @(negedge clk);
    want("param_rd0", 8'h11); obs(param_rdata);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_overflow;
    logic [7:0] e, o; string nm;
    for (int k = 3; k < 64; k++) bus_write(REG_PARAM_DATA, 8'(k) ^ 8'h5A);
    bus_write(REG_PARAM_DATA, 8'hEE);
    want("ovf_pcount", 8'd64); bus_read(REG_PARAM_COUNT);
    want("ovf_status", 8'h14); bus_read(REG_STATUS);
    @(negedge clk); param_raddr = 6'd63;
    @(negedge clk);
    want("ovf_word63", 8'h3F ^ 8'h5A); obs(param_rdata);
    bus_write(REG_CTRL, 8'h01);
    want("clr_status", 8'h00); bus_read(REG_STATUS);
    want("clr_pcount", 8'h00); bus_read(REG_PARAM_COUNT);
    want("clr_icount", 8'h00); bus_read(REG_IMG_COUNT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_run;
    logic [7:0] e, o; string nm;
    bus_write(REG_PARAM_DATA, 8'h01);
    bus_write(REG_CTRL, 8'h02);
    want("err_no_img_status", 8'h20); bus_read(REG_STATUS);
    want("err_no_pulse", 8'(exp_pulses)); obs(8'(start_cnt));
    bus_write(REG_CTRL, 8'h01);
    bus_write(REG_PARAM_DATA, 8'h07);
    bus_write(REG_IMG_DATA, 8'h08);
    bus_write(REG_IMG_DATA, 8'h09);
    bus_write(REG_CTRL, 8'h02);
    exp_pulses++;
    want("start_high", 8'h01); obs({7'd0, core_start});
    @(negedge clk);
    want("start_low", 8'h00);  obs({7'd0, core_start});
    want("run_status", 8'h01); bus_read(REG_STATUS);
    bus_write(REG_IMG_DATA, 8'hFF);
    want("run_icount", 8'd2);  bus_read(REG_IMG_COUNT);
    want("run_err_status", 8'h21); bus_read(REG_STATUS);
    bus_write(REG_CTRL, 8'h02);
    want("run_start_ignored", 8'(exp_pulses)); obs(8'(start_cnt));
    pulse_done(8'hA5);
    want("done_status", 8'h22); bus_read(REG_STATUS);
    want("done_result", 8'hA5); bus_read(REG_RESULT);
    want("after_result_status", 8'h20); bus_read(REG_STATUS);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, o; string nm;
    bus_write(REG_CTRL, 8'h01);
    bus_write(REG_PARAM_DATA, 8'h10);
    bus_write(REG_IMG_DATA, 8'h20);
    bus_write(REG_CTRL, 8'h02);
    exp_pulses++;
    pulse_done(8'h77);
    want("b2b_done_status", 8'h02); bus_read(REG_STATUS);
    bus_write(REG_CTRL, 8'h02);
    exp_pulses++;
    want("b2b_rerun_status", 8'h01); bus_read(REG_STATUS);
    want("b2b_pulses", 8'(exp_pulses)); obs(8'(start_cnt));
    pulse_done(8'h88);
    want("b2b_result", 8'h88); bus_read(REG_RESULT);
    want("b2b_idle_status", 8'h00); bus_read(REG_STATUS);
    want("b2b_pcount_kept", 8'd1); bus_read(REG_PARAM_COUNT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] e, o; string nm;
    bus_read(REG_RESULT);
    obs_q.delete();
    bus_write(REG_CTRL, 8'h02);
    exp_pulses++;
    want("mid_busy", 8'h01); bus_read(REG_STATUS);
    @(negedge clk); reset = 1'b0;
    #1;
    want("mid_rst_readdata", 8'h00); obs(bus.readdata);
    want("mid_rst_core_start", 8'h00); obs({7'd0, core_start});
    @(negedge clk); reset = 1'b1;
    pulse_done(8'h5A);
    want("mid_status", 8'h00); bus_read(REG_STATUS);
    want("mid_result", 8'h00); bus_read(REG_RESULT);
    want("mid_pcount", 8'h00); bus_read(REG_PARAM_COUNT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_clear_vs_done;
    logic [7:0] e, o; string nm;
    bus_write(REG_PARAM_DATA, 8'h31);
    bus_write(REG_IMG_DATA, 8'h32);
    bus_write(REG_CTRL, 8'h02);
    exp_pulses++;
    want("cvd_busy", 8'h01); bus_read(REG_STATUS);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = REG_CTRL; bus.writedata = 8'h01;
    core_done = 1'b1; core_result = 8'h3C;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0; core_done = 1'b0;
    want("cvd_status", 8'h00); bus_read(REG_STATUS);
    want("cvd_result", 8'h00); bus_read(REG_RESULT);
    want("cvd_pulses", 8'(exp_pulses)); obs(8'(start_cnt));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = name_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_checks++;
      if (o !== e) $display("FAIL %s: got 0x%h, want 0x%h", nm, o, e);
      else n_pass++;
    end
    obs_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    core_done = 1'b0; core_result = '0;
    param_raddr = '0; img_raddr = '0;
    reset = 1'b0;
    test_reset();
    test_load();
    test_overflow();
    test_run();
    test_back_to_back();
    test_reset_mid_run();
    test_clear_vs_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
